// File: rtl/dac_play_sequencer.sv
// Waveform playback controller: reads a stored pass from block RAM through a prefetch FIFO
// and streams it to the DAC transfer stage, emitting all-zero silence whenever not playing.
module dac_play_sequencer #(
  parameter int DWIDTH     = 128,
  parameter int AWIDTH     = 12,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [AWIDTH-1:0] cfg_last_addr,
  input  logic [15:0]       cfg_loops,
  output logic              bram_en,
  output logic [AWIDTH-1:0] bram_addr,
  input  logic [DWIDTH-1:0] bram_rdata,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

  state_t state, state_next;

  logic [AWIDTH-1:0]     last_addr_q;
  logic [15:0]           loops_q;
  logic [AWIDTH-1:0]     rd_addr;
  logic [15:0]           pass_cnt;
  logic [RD_LATENCY-1:0] v_pipe;
  logic [RD_LATENCY-1:0] t_pipe;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         out_left;

  logic [DWIDTH-1:0]     fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic aborted;
  logic first_seen;
  logic tvalid_q;
  logic done_q;
  logic underrun_q;

  logic start_ok;
  logic abort;
  logic issue;
  logic wrap;
  logic final_issue;
  logic retire;
  logic push;
  logic pop;
  logic has_word;
  logic fifo_empty_next;

  // Issue is throttled so that every read in flight is guaranteed a FIFO slot on arrival.
  always_comb begin
    start_ok        = (state == IDLE) && cfg_start && !cfg_stop;
    abort           = (state != IDLE) && cfg_stop;
    issue           = (state == PLAY) && !cfg_stop &&
                      ((outstanding + count) < CW'(FIFO_DEPTH));
    wrap            = (rd_addr == last_addr_q);
    final_issue     = issue && (loops_q != 16'd0) && wrap && (pass_cnt == loops_q);
    retire          = v_pipe[RD_LATENCY-1];
    push            = retire && !aborted && !abort;
    has_word        = (count != '0) && (state != IDLE);
    pop             = tvalid_q && m_axis_tready && has_word && !abort;
    out_left        = outstanding - CW'(retire);
    fifo_empty_next = (count == '0) || ((count == CW'(1)) && pop);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) state_next = PLAY;
      end
      PLAY: begin
        if (abort)            state_next = (out_left == '0) ? IDLE : DRAIN;
        else if (final_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (abort || aborted) begin
          if (out_left == '0) state_next = IDLE;
        end else if ((outstanding == '0) && fifo_empty_next) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bram_en       = issue;
    bram_addr     = rd_addr;
    m_axis_tdata  = has_word ? fifo_data[rd_ptr] : '0;
    m_axis_tlast  = has_word ? fifo_last[rd_ptr] : 1'b0;
    m_axis_tvalid = tvalid_q;
    busy          = (state != IDLE);
    done          = done_q;
    underrun      = underrun_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      last_addr_q <= '0;
      loops_q     <= '0;
      rd_addr     <= '0;
      pass_cnt    <= '0;
      aborted     <= 1'b0;
      first_seen  <= 1'b0;
      tvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state    <= state_next;
      tvalid_q <= 1'b1;
      done_q   <= (state != IDLE) && (state_next == IDLE);
      if (start_ok) begin
        last_addr_q <= cfg_last_addr;
        loops_q     <= cfg_loops;
        rd_addr     <= '0;
        pass_cnt    <= 16'd1;
        aborted     <= 1'b0;
        first_seen  <= 1'b0;
        underrun_q  <= 1'b0;
      end
      if (issue) begin
        rd_addr <= wrap ? '0 : rd_addr + AWIDTH'(1);
        if (wrap) pass_cnt <= pass_cnt + 16'd1;
      end
      if (abort) aborted <= 1'b1;
      if (push) first_seen <= 1'b1;
      if ((state == PLAY) && first_seen && (count == '0)) underrun_q <= 1'b1;
    end
  end

  // Valid/tlast tags travel alongside the RAM read so data can be matched on arrival.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v_pipe      <= '0;
      t_pipe      <= '0;
      outstanding <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        v_pipe[i] <= v_pipe[i-1];
        t_pipe[i] <= t_pipe[i-1];
      end
      v_pipe[0]   <= issue;
      t_pipe[0]   <= issue && wrap;
      outstanding <= outstanding + CW'(issue) - CW'(retire);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bram_rdata;
      fifo_last[wr_ptr] <= t_pipe[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_dac_play_sequencer.sv
// Scoreboard bench for dac_play_sequencer: directed runs push expected words into a queue,
// and an independent monitor pops and compares every word the DUT hands downstream.
module tb_dac_play_sequencer;

  localparam int DW = 128;
  localparam int AW = 12;
  localparam int RL = 2;
  localparam int FD = 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [AW-1:0] cfg_last_addr = '0;
  logic [15:0]   cfg_loops = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          busy;
  logic          done;
  logic          underrun;

  dac_play_sequencer #(.DWIDTH(DW), .AWIDTH(AW), .RD_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .aclk(aclk), .areset(areset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_last_addr(cfg_last_addr), .cfg_loops(cfg_loops), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_rdata(bram_rdata), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [DW-1:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc, first_word_cyc, first_en_cyc, done_cyc, done_cnt;
  int accepted, issued, max_inflight;
  logic [AW-1:0] first_en_addr;
  bit rand_ready = 1'b0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [RL];

  // Nonzero words so that real data can never be mistaken for silence.
  function automatic logic [DW-1:0] word_of(input int i);
    logic [15:0] a;
    a = 16'(i);
    return {16'hA5C3, {(DW-32){1'b0}}, a};
  endfunction

  initial for (int i = 0; i < (1 << AW); i++) ram[i] = word_of(i);

  always @(posedge aclk) begin
    for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= bram_en ? ram[bram_addr] : '0;
    cyc <= cyc + 1;
  end
  assign bram_rdata = rd_pipe[RL-1];

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (issued - accepted > max_inflight) max_inflight = issued - accepted;
      if (bram_en) begin
        issued++;
        if (first_en_cyc < 0) begin
          first_en_cyc  = cyc;
          first_en_addr = bram_addr;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tdata != '0) begin
        exp_t e;
        if (first_word_cyc < 0) first_word_cyc = cyc;
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("word_data", m_axis_tdata, e.data);
          checkOutput("word_last", DW'(m_axis_tlast), DW'(e.last));
        end
      end
    end
  end

  task automatic clear_records();
    first_word_cyc = -1;
    first_en_cyc   = -1;
    done_cyc       = -1;
    done_cnt       = 0;
    accepted       = 0;
    issued         = 0;
    max_inflight   = 0;
  endtask

  task automatic push_expect(input int last, input int loops);
    for (int p = 0; p < loops; p++)
      for (int a = 0; a <= last; a++) exp_q.push_back('{word_of(a), a == last});
  endtask

  task automatic applyStimulus(input int last, input int loops);
    @(negedge aclk);
    clear_records();
    cfg_last_addr = AW'(last);
    cfg_loops     = 16'(loops);
    cfg_start     = 1'b1;
    start_cyc     = cyc;
    @(negedge aclk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge aclk);
    checkOutput("idle_timeout", DW'(busy), '0);
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_fall;
    int nonzero;
    clear_records();
    areset = 1'b0;
    #1 areset = 1'b1;
    #20;
    checkOutput("rst_tvalid", DW'(m_axis_tvalid), '0);
    checkOutput("rst_tdata", m_axis_tdata, '0);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_bram_en", DW'(bram_en), '0);
    checkOutput("rst_underrun", DW'(underrun), '0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("tvalid_after_rst", DW'(m_axis_tvalid), 1);
    checkOutput("idle_silence", m_axis_tdata, '0);

    // Basic two-pass playback with exact latency and done timing
    applyStimulus(3, 2);
    push_expect(3, 2);
    wait_idle(100);
    checkOutput("t1_en_cycle", DW'(first_en_cyc), DW'(start_cyc + 1));
    checkOutput("t1_en_addr", DW'(first_en_addr), '0);
    checkOutput("t1_first_word", DW'(first_word_cyc), DW'(start_cyc + RL + 2));
    checkOutput("t1_done_cycle", DW'(done_cyc), DW'(start_cyc + RL + 2 + 8));
    checkOutput("t1_done_cnt", DW'(done_cnt), 1);
    checkOutput("t1_words", DW'(accepted), 8);
    checkOutput("t1_underrun", DW'(underrun), '0);
    checkOutput("t1_q_empty", DW'(exp_q.size()), '0);

    // Start while busy, and start+stop together in idle, are both ignored
    applyStimulus(3, 2);
    push_expect(3, 2);
    repeat (2) @(negedge aclk);
    cfg_last_addr = AW'(7);
    cfg_loops     = 16'd5;
    cfg_start     = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    wait_idle(100);
    checkOutput("t4_done_cycle", DW'(done_cyc), DW'(start_cyc + RL + 2 + 8));
    checkOutput("t4_words", DW'(accepted), 8);
    checkOutput("t4_q_empty", DW'(exp_q.size()), '0);
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    @(negedge aclk);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    repeat (4) @(negedge aclk);
    checkOutput("t4_startstop_busy", DW'(busy), '0);
    checkOutput("t4_startstop_done", DW'(done_cnt), 1);

    // Single-word pass: every word carries tlast
    applyStimulus(0, 4);
    push_expect(0, 4);
    wait_idle(100);
    checkOutput("t6_words", DW'(accepted), 4);
    checkOutput("t6_done_cnt", DW'(done_cnt), 1);
    checkOutput("t6_done_cycle", DW'(done_cyc), DW'(start_cyc + RL + 2 + 4));
    checkOutput("t6_q_empty", DW'(exp_q.size()), '0);

    // Random backpressure
    rand_ready = 1'b1;
    applyStimulus(9, 3);
    push_expect(9, 3);
    wait_idle(1000);
    rand_ready = 1'b0;
    checkOutput("t3_words", DW'(accepted), 30);
    checkOutput("t3_underrun", DW'(underrun), '0);
    checkOutput("t3_inflight_ok", DW'(max_inflight <= FD), 1);
    checkOutput("t3_q_empty", DW'(exp_q.size()), '0);

    // Endless loop aborted after 100 words
    applyStimulus(15, 0);
    push_expect(15, 10);
    for (int i = 0; i < 500 && accepted < 100; i++) @(negedge aclk);
    checkOutput("t2_reached_100", DW'(accepted >= 100), 1);
    cfg_stop = 1'b1;
    start_cyc = cyc;
    @(negedge aclk);
    cfg_stop = 1'b0;
    checkOutput("t2_silent_after_stop", m_axis_tdata, '0);
    checkOutput("t2_bram_en_low", DW'(bram_en), '0);
    busy_fall = -1;
    nonzero = 0;
    for (int i = 0; i < 10; i++) begin
      if (!busy && busy_fall < 0) busy_fall = cyc;
      if (m_axis_tdata != '0 || m_axis_tlast) nonzero++;
      @(negedge aclk);
    end
    checkOutput("t2_busy_fall", DW'(busy_fall >= 0 && busy_fall - start_cyc <= RL), 1);
    checkOutput("t2_no_stale", DW'(nonzero), '0);
    exp_q.delete();

    // Asynchronous reset mid-pass, then a fresh run
    applyStimulus(15, 0);
    push_expect(15, 4);
    for (int i = 0; i < 200 && accepted < 20; i++) @(negedge aclk);
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    checkOutput("t5_rst_tvalid", DW'(m_axis_tvalid), '0);
    checkOutput("t5_rst_tdata", m_axis_tdata, '0);
    checkOutput("t5_rst_busy", DW'(busy), '0);
    checkOutput("t5_rst_bram_en", DW'(bram_en), '0);
    exp_q.delete();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("t5_tvalid_back", DW'(m_axis_tvalid), 1);
    applyStimulus(3, 1);
    push_expect(3, 1);
    wait_idle(100);
    checkOutput("t5_en_addr", DW'(first_en_addr), '0);
    checkOutput("t5_first_word", DW'(first_word_cyc), DW'(start_cyc + RL + 2));
    checkOutput("t5_words", DW'(accepted), 4);
    checkOutput("t5_q_empty", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
